// File: rtl/mem_loader.sv
// Boot loader: assembles little-endian words from a UART byte stream into data memory,
// then hands the memory port to the core through a combinational pass-through mux.
module mem_loader #(
  parameter int unsigned MEMORY_SIZE = 262143,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_w_data,
  output logic [31:0] core_r_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data,
  output logic        loading,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    ST_HDR,
    ST_DATA,
    ST_DONE,
    ST_ERR
  } state_t;

  // Widened to 33 bits so the capacity check cannot overflow for a full memory.
  localparam logic [32:0] MaxWords = 33'(MEMORY_SIZE) + 33'd1 - 33'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [1:0]  byteCnt_q, byteCnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] wordCnt_q, wordCnt_d;
  logic [31:0] wordIdx_q, wordIdx_d;
  logic        memWe_q, memWe_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWData_q, memWData_d;

  logic [31:0] assembled;
  logic        byteAccept;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_HDR;
      byteCnt_q  <= 2'd0;
      shift_q    <= 32'd0;
      wordCnt_q  <= 32'd0;
      wordIdx_q  <= 32'd0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 32'd0;
      memWData_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      shift_q    <= shift_d;
      wordCnt_q  <= wordCnt_d;
      wordIdx_q  <= wordIdx_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWData_q <= memWData_d;
    end
  end

  // Bytes shift in from the top, so after four bytes the first one sits in bits 7:0.
  assign assembled  = {rx_data, shift_q[31:8]};
  assign byteAccept = rx_valid &&
                      ((state_q == ST_HDR) ||
                       ((state_q == ST_DATA) && (wordIdx_q != wordCnt_q)));

  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    shift_d    = shift_q;
    wordCnt_d  = wordCnt_q;
    wordIdx_d  = wordIdx_q;
    memWe_d    = 1'b0;
    memAddr_d  = memAddr_q;
    memWData_d = memWData_q;

    if (byteAccept) begin
      shift_d   = assembled;
      byteCnt_d = byteCnt_q + 2'd1;
      if (byteCnt_q == 2'd3) begin
        if (state_q == ST_HDR) begin
          wordCnt_d = assembled;
          wordIdx_d = 32'd0;
          if (assembled == 32'd0) begin
            state_d = ST_DONE;
          end else if ({1'b0, assembled} > MaxWords) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          memWe_d    = 1'b1;
          memAddr_d  = 32'(BASE_ADDR) + wordIdx_q;
          memWData_d = assembled;
          wordIdx_d  = wordIdx_q + 32'd1;
        end
      end
    end

    // Leave DATA only once the final write pulse is actually on the port.
    if ((state_q == ST_DATA) && memWe_q && (wordIdx_q == wordCnt_q)) begin
      state_d = ST_DONE;
    end
  end

  assign done        = (state_q == ST_DONE);
  assign error       = (state_q == ST_ERR);
  assign loading     = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign core_r_data = mem_r_data;
  assign mem_we      = done ? core_we     : memWe_q;
  assign mem_addr    = done ? core_addr   : memAddr_q;
  assign mem_w_data  = done ? core_w_data : memWData_q;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized bench for mem_loader: byte streams are checked against a word-level
// model of the load (header count, capacity rule, little-endian word assembly).
module tb_mem_loader;

  localparam int unsigned MemSize  = 7;
  localparam int unsigned BaseAddr = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        core_we = 1'b0;
  logic [31:0] core_addr = 32'd0;
  logic [31:0] core_w_data = 32'd0;
  logic [31:0] core_r_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data = 32'd0;
  logic        loading;
  logic        done;
  logic        error;

  mem_loader #(.MEMORY_SIZE(MemSize), .BASE_ADDR(BaseAddr)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .core_we(core_we), .core_addr(core_addr), .core_w_data(core_w_data),
    .core_r_data(core_r_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .loading(loading),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int totalCount = 0;
  int badCount = 0;
  int cycleNum = 0;
  int lastWeCycle = -1;
  int doneRiseCycle = -1;
  logic donePrev = 1'b0;
  logic noiseOn = 1'b0;

  logic [7:0]  txBytes[$];
  logic [63:0] obsQ[$];
  logic [63:0] expQ[$];
  logic        expDone;
  logic        expErr;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Loader-side writes only; once done the port belongs to the core.
  always @(negedge clk) begin
    if (mem_we && !done) begin
      obsQ.push_back({mem_addr, mem_w_data});
      lastWeCycle = cycleNum;
    end
    if (done && !donePrev) doneRiseCycle = cycleNum;
    donePrev = done;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalCount++;
    assert (observed === expected)
    else begin
      badCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    mem_r_data = $urandom;
    if (noiseOn) begin
      core_we     = 1'($urandom_range(1, 0));
      core_addr   = $urandom;
      core_w_data = $urandom;
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    stepCycle();
    stepCycle();
    rstn = 1'b1;
  endtask

  task automatic applyStimulus(input int maxGap);
    int gap;
    for (int i = 0; i < txBytes.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = txBytes[i];
      stepCycle();
      rx_valid = 1'b0;
      if (maxGap > 0 && i != txBytes.size() - 1) begin
        gap = $urandom_range(maxGap, 0);
        repeat (gap) stepCycle();
      end
    end
  endtask

  function automatic void buildModel();
    logic [31:0] n;
    logic [31:0] w;
    expQ.delete();
    n = {txBytes[3], txBytes[2], txBytes[1], txBytes[0]};
    expErr  = 1'b0;
    expDone = 1'b0;
    if (n == 0) begin
      expDone = 1'b1;
    end else if (64'(n) > 64'(MemSize) + 64'd1 - 64'(BaseAddr)) begin
      expErr = 1'b1;
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        w = {txBytes[4*k+7], txBytes[4*k+6], txBytes[4*k+5], txBytes[4*k+4]};
        expQ.push_back({BaseAddr + 32'(k), w});
      end
      expDone = (txBytes.size() >= 4 + 4 * int'(n));
    end
  endfunction

  function automatic void makeStream(input logic [31:0] n, input int words);
    txBytes.delete();
    for (int b = 0; b < 4; b++) txBytes.push_back(n[8*b +: 8]);
    for (int k = 0; k < words; k++) begin
      logic [31:0] w;
      w = $urandom;
      for (int b = 0; b < 4; b++) txBytes.push_back(w[8*b +: 8]);
    end
  endfunction

  task automatic runCase(input string name, input int maxGap, input logic withReset);
    int base;
    if (withReset) doReset();
    base = obsQ.size();
    buildModel();
    applyStimulus(maxGap);
    if (maxGap == 0 && expDone && expQ.size() == 0)
      checkOutput({name, ".doneNext"}, 64'(done), 64'd1);
    if (maxGap == 0 && expQ.size() > 0) begin
      checkOutput({name, ".lastWe"}, 64'(mem_we), 64'd1);
      checkOutput({name, ".lastAddr"}, 64'(mem_addr), 64'(expQ[expQ.size()-1][63:32]));
    end
    repeat (3) stepCycle();
    checkOutput({name, ".count"}, 64'(obsQ.size() - base), 64'(expQ.size()));
    for (int k = 0; k < expQ.size(); k++)
      if (base + k < obsQ.size())
        checkOutput($sformatf("%s.wr%0d", name, k), obsQ[base+k], expQ[k]);
    checkOutput({name, ".done"}, 64'(done), 64'(expDone));
    checkOutput({name, ".error"}, 64'(error), 64'(expErr));
    checkOutput({name, ".loading"}, 64'(loading), 64'(!expDone && !expErr));
    if (expQ.size() > 0 && expDone)
      checkOutput({name, ".doneLat"}, 64'(doneRiseCycle), 64'(lastWeCycle + 1));
  endtask

  initial begin
    rstn = 1'b0;
    stepCycle();
    checkOutput("rst.loading", 64'(loading), 64'd1);
    checkOutput("rst.done", 64'(done), 64'd0);
    checkOutput("rst.error", 64'(error), 64'd0);
    checkOutput("rst.memPort", {31'd0, mem_we, mem_addr}, 64'd0);
    checkOutput("rst.wdata", 64'(mem_w_data), 64'd0);
    checkOutput("rst.rdata", 64'(core_r_data), 64'(mem_r_data));

    makeStream(32'd2, 0);
    for (int b = 0; b < 4; b++) txBytes.push_back(8'(32'h43000000 >> (8*b)));
    for (int b = 0; b < 4; b++) txBytes.push_back(8'(32'h3F666666 >> (8*b)));
    runCase("known", 0, 1'b1);

    makeStream(32'd0, 0);
    runCase("zero", 0, 1'b1);

    makeStream(32'd5, 2);
    runCase("over", 0, 1'b1);
    makeStream(32'd4, 4);
    runCase("full", 0, 1'b1);

    noiseOn = 1'b1;
    for (int it = 0; it < 3; it++) begin
      makeStream(32'($urandom_range(4, 1)), 0);
      for (int k = 0; k < int'({txBytes[3], txBytes[2], txBytes[1], txBytes[0]}); k++)
        for (int b = 0; b < 4; b++) txBytes.push_back(8'($urandom));
      runCase($sformatf("gap%0d", it), 5, 1'b1);
      runCase($sformatf("b2b%0d", it), 0, 1'b1);
    end
    noiseOn = 1'b0;

    core_we = 1'b1;
    core_addr = 32'h10;
    core_w_data = 32'hDEADBEEF;
    mem_r_data = 32'h12345678;
    #1;
    checkOutput("pass.we", 64'(mem_we), 64'd1);
    checkOutput("pass.addr", 64'(mem_addr), 64'h10);
    checkOutput("pass.data", 64'(mem_w_data), 64'hDEADBEEF);
    checkOutput("pass.rdata", 64'(core_r_data), 64'h12345678);
    core_we = 1'b0;
    makeStream(32'd1, 1);
    applyStimulus(0);
    checkOutput("pass.weOff", 64'(mem_we), 64'd0);
    checkOutput("pass.stillDone", 64'(done), 64'd1);

    doReset();
    makeStream(32'd3, 2);
    txBytes.push_back(8'hA5);
    applyStimulus(0);
    stepCycle();
    rstn = 1'b0;
    stepCycle();
    rstn = 1'b1;
    checkOutput("midRst.loading", 64'(loading), 64'd1);
    checkOutput("midRst.done", 64'(done), 64'd0);
    makeStream(32'd1, 1);
    runCase("midRst", 0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
